adc_snapshot: RTL and testbench
===============================

# adc_snapshot

Single-channel triggered capture buffer for the ADC front end. Sits directly downstream of the sample-format/register stage, taking its four 80-bit offset-corrected channel buses (8 × 10-bit two's-complement samples per word, sample 0 in bits [9:0]) on the fast parallel clock. On arm it waits for a trigger, writes a programmable number of words from one selected channel into block RAM, then holds them for register-bus readback.

## Interface
Parameters:
- SERDES_RATIO, 8, samples per word; word width = 10·SERDES_RATIO.
- DEPTH_LOG2, 10, buffer depth = 2^DEPTH_LOG2 words.

Ports:
- clk_div_a  in  1  parallel sample clock; only clock in the block.
- rst  in  1  synchronous, active-high reset.
- dataA_in, dataB_in, dataC_in, dataD_in  in  80 each  signed sample words, channels A–D.
- din_valid  in  1  qualifies all four data inputs this cycle; already synchronous to clk_div_a.
- ch_sel  in  2  0=A, 1=B, 2=C, 3=D; sampled on arm.
- trig_mode  in  2  0=immediate, 1=external, 2=level, 3=reserved (treated as 0); sampled on arm.
- trig_ext  in  1  external trigger, level-sensitive, synchronous.
- thresh  in  10  signed level threshold; sampled on arm.
- num_words  in  DEPTH_LOG2+1  words to capture; 0 or > 2^DEPTH_LOG2 means 2^DEPTH_LOG2; sampled on arm.
- arm  in  1  single-cycle start pulse.
- disarm  in  1  single-cycle abort pulse.
- rd_addr  in  DEPTH_LOG2  readback word address.
- rd_data  out  80  readback word.
- busy  out  1  high in WAIT_TRIG or CAPTURE.
- done  out  1  high in DONE.
- wr_count  out  DEPTH_LOG2+1  words written in the current/last capture.
- trig_latency  out  32  valid cycles from arm to trigger, saturating at 0xFFFFFFFF.

## Operation
- States: IDLE, WAIT_TRIG, CAPTURE, DONE. Reset → IDLE.
- IDLE/DONE + arm → WAIT_TRIG; latch ch_sel, trig_mode, thresh, num_words; clear wr_count and trig_latency. arm in WAIT_TRIG/CAPTURE is ignored.
- disarm in any state → IDLE next cycle; wr_count and memory keep their values. disarm and arm in the same cycle: disarm wins.
- WAIT_TRIG: each din_valid cycle, the selected word is tested:
  - mode 0: trigger on the first valid word.
  - mode 1: trigger when trig_ext=1 and din_valid=1.
  - mode 2: trigger when any sample of the word is > thresh (signed 10-bit compare; thresh=511 never fires).
  - The triggering word is written as word 0, so CAPTURE begins with wr_count=1. If num_words=1 → DONE directly.
  - A non-triggering valid word increments trig_latency (saturating).
- CAPTURE: each din_valid word is written at address wr_count[DEPTH_LOG2-1:0]; wr_count increments. Invalid cycles write nothing. When wr_count reaches the latched target → DONE. No wrap: addresses never exceed target−1.
- DONE: hold until arm or disarm.
- Memory is simple dual-port: write from the capture side, read from rd_addr. Reads are allowed in any state; a read during CAPTURE returns old or new data at the collision address (no ordering guarantee). Memory content is not cleared by reset.

## Timing
- Reset values: rd_data=0, busy=0, done=0, wr_count=0, trig_latency=0.
- Control outputs are registered and follow the state one cycle after the triggering edge. arm at cycle N gives busy=1 at N+1. The first word eligible for trigger is the word present at N+1.
- Word at trigger cycle T lands at address 0. wr_count=1 is visible at T+1. The last write at cycle L gives done=1 and busy=0 at L+1.
- Read latency: rd_addr at cycle N → rd_data at N+1 (registered BRAM output). Throughput is one read per cycle.
- rst mid-capture: IDLE next cycle, all outputs return to reset values, and a partial buffer remains in memory.

## Test plan
- Immediate, ch B, num_words=4, din_valid continuous, dataB word k = {8{10'(k)}} → done after 4 valid cycles; rd addr0..3 = words 0..3; wr_count=4; trig_latency=0.
- Level, ch C, thresh=100, words with max sample 50,50,101,… → word with 101 at address 0; trig_latency=2.
- External, din_valid toggling 1010…, trig_ext high on an invalid cycle then a valid one → trigger on the valid cycle only; num_words=3 completes after 3 further valid-qualified writes (including the trigger word).
- num_words=0, DEPTH_LOG2=10 → exactly 1024 words captured, wr_count=1024, no wrap onto address 0.
- disarm during CAPTURE after 5 words, with arm asserted the same cycle → IDLE, wr_count=5, busy=0, done=0; a later arm restarts with wr_count=0.
- rst asserted for 1 cycle in WAIT_TRIG → all outputs at reset values next cycle; trig_ext ignored until the next arm.

Source files
------------

// File: rtl/adc_snapshot.sv
// adc_snapshot
// Single-channel triggered capture buffer for the ADC front end.
// After an arm pulse it waits for a trigger on one selected channel. It then
// writes a programmable number of sample words into block RAM and holds them
// for register-bus readback.
//
// Ports
//   clk_div_a        parallel sample clock (only clock)
//   rst              synchronous, active-high reset
//   dataX_in (A..D)  80-bit words, 8 x 10-bit signed samples, sample 0 in [9:0]
//   din_valid        qualifies all four data words this cycle
//   ch_sel           channel select 0=A 1=B 2=C 3=D (latched on arm)
//   trig_mode        0=immediate 1=external 2=level 3=immediate (latched on arm)
//   trig_ext         external trigger level, synchronous
//   thresh           signed level threshold (latched on arm)
//   num_words        capture length; 0 or > depth means full depth (latched on arm)
//   arm / disarm     single-cycle start / abort pulses
//   rd_addr          readback word address
//   rd_data          readback word, one cycle after rd_addr
//   busy / done      status: waiting or capturing / capture complete
//   wr_count         words written in the current or last capture
//   trig_latency     valid cycles from arm to trigger, saturating
//
// state      | meaning
// -----------+-----------------------------------------------------
// S_IDLE     | not armed; arm starts a new capture
// S_WAIT_TRIG| armed; test each valid word against the trigger rule
// S_CAPTURE  | trigger seen; write every valid word until target
// S_DONE     | buffer full; hold for readback until arm or disarm

module adc_snapshot #(
  parameter int SERDES_RATIO = 8,
  parameter int DEPTH_LOG2   = 10
) (
  input  logic                       clk_div_a,
  input  logic                       rst,
  input  logic [10*SERDES_RATIO-1:0] dataA_in,
  input  logic [10*SERDES_RATIO-1:0] dataB_in,
  input  logic [10*SERDES_RATIO-1:0] dataC_in,
  input  logic [10*SERDES_RATIO-1:0] dataD_in,
  input  logic                       din_valid,
  input  logic [1:0]                 ch_sel,
  input  logic [1:0]                 trig_mode,
  input  logic                       trig_ext,
  input  logic [9:0]                 thresh,
  input  logic [DEPTH_LOG2:0]        num_words,
  input  logic                       arm,
  input  logic                       disarm,
  input  logic [DEPTH_LOG2-1:0]      rd_addr,
  output logic [10*SERDES_RATIO-1:0] rd_data,
  output logic                       busy,
  output logic                       done,
  output logic [DEPTH_LOG2:0]        wr_count,
  output logic [31:0]                trig_latency
);

  localparam int W     = 10 * SERDES_RATIO;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_CNT  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [31:0]         LAT_MAX  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            ch_q, ch_d;
  logic [1:0]            mode_q, mode_d;
  logic [9:0]            thresh_q, thresh_d;
  logic [DEPTH_LOG2:0]   target_q, target_d;
  logic [DEPTH_LOG2:0]   wr_count_q, wr_count_d;
  logic [31:0]           trig_lat_q, trig_lat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [W-1:0]          rd_data_q;

  logic [W-1:0]          sel_word;
  logic                  level_hit;
  logic                  trig_fire;
  logic [DEPTH_LOG2:0]   target_norm;

  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [W-1:0]          wr_word;

  logic [W-1:0]          mem [DEPTH];

  always_comb begin
    sel_word = dataA_in;
    case (ch_q)
      2'd0:    sel_word = dataA_in;
      2'd1:    sel_word = dataB_in;
      2'd2:    sel_word = dataC_in;
      default: sel_word = dataD_in;
    endcase
  end

  // A threshold of +511 can never be exceeded by a 10-bit signed sample,
  // so that setting naturally disables the level trigger.
  always_comb begin
    level_hit = 1'b0;
    for (int s = 0; s < SERDES_RATIO; s++) begin
      if ($signed(sel_word[10*s +: 10]) > $signed(thresh_q)) begin
        level_hit = 1'b1;
      end
    end
  end

  always_comb begin
    case (mode_q)
      2'd1:    trig_fire = trig_ext;
      2'd2:    trig_fire = level_hit;
      default: trig_fire = 1'b1;
    endcase
  end

  // Out-of-range lengths (zero or beyond the buffer) mean "fill the buffer".
  always_comb begin
    if ((num_words == '0) || (num_words > FULL_CNT)) begin
      target_norm = FULL_CNT;
    end else begin
      target_norm = num_words;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    thresh_d   = thresh_q;
    target_d   = target_q;
    wr_count_d = wr_count_q;
    trig_lat_d = trig_lat_q;
    wr_en      = 1'b0;
    wr_addr    = wr_count_q[DEPTH_LOG2-1:0];
    wr_word    = sel_word;

    // Abort takes priority over everything, including a word that happens
    // to be valid in the same cycle: nothing is written on a disarm cycle.
    if (disarm) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            ch_d       = ch_sel;
            mode_d     = trig_mode;
            thresh_d   = thresh;
            target_d   = target_norm;
            wr_count_d = '0;
            trig_lat_d = '0;
            state_d    = S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (din_valid) begin
            if (trig_fire) begin
              wr_en      = 1'b1;
              wr_addr    = '0;
              wr_count_d = ONE_CNT;
              state_d    = (target_q == ONE_CNT) ? S_DONE : S_CAPTURE;
            end else if (trig_lat_q != LAT_MAX) begin
              trig_lat_d = trig_lat_q + 32'd1;
            end
          end
        end
        S_CAPTURE: begin
          if (din_valid) begin
            wr_en      = 1'b1;
            wr_count_d = wr_count_q + ONE_CNT;
            if (wr_count_d == target_q) begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_WAIT_TRIG) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_div_a) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      mode_q     <= '0;
      thresh_q   <= '0;
      target_q   <= '0;
      wr_count_q <= '0;
      trig_lat_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      mode_q     <= mode_d;
      thresh_q   <= thresh_d;
      target_q   <= target_d;
      wr_count_q <= wr_count_d;
      trig_lat_q <= trig_lat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_data_q  <= mem[rd_addr];
    end
  end

  // Buffer contents survive reset; a reset cycle only blocks the write so a
  // partial capture is left exactly as it was.
  always_ff @(posedge clk_div_a) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= wr_word;
    end
  end

  assign rd_data      = rd_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_count     = wr_count_q;
  assign trig_latency = trig_lat_q;

endmodule

// File: tb/tb_adc_snapshot.sv
module tb_adc_snapshot;
  localparam int SR    = 8;
  localparam int DL    = 10;
  localparam int W     = 10 * SR;
  localparam int DEPTH = 1 << DL;
  localparam int MAXC  = 2000;

  logic          clk_div_a = 1'b0;
  logic          rst;
  logic [W-1:0]  dataA_in, dataB_in, dataC_in, dataD_in;
  logic          din_valid;
  logic [1:0]    ch_sel;
  logic [1:0]    trig_mode;
  logic          trig_ext;
  logic [9:0]    thresh;
  logic [DL:0]   num_words;
  logic          arm;
  logic          disarm;
  logic [DL-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic [DL:0]   wr_count;
  logic [31:0]   trig_latency;

  always #5 clk_div_a = ~clk_div_a;

  adc_snapshot #(.SERDES_RATIO(SR), .DEPTH_LOG2(DL)) dut (
    .clk_div_a    (clk_div_a),
    .rst          (rst),
    .dataA_in     (dataA_in),
    .dataB_in     (dataB_in),
    .dataC_in     (dataC_in),
    .dataD_in     (dataD_in),
    .din_valid    (din_valid),
    .ch_sel       (ch_sel),
    .trig_mode    (trig_mode),
    .trig_ext     (trig_ext),
    .thresh       (thresh),
    .num_words    (num_words),
    .arm          (arm),
    .disarm       (disarm),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .wr_count     (wr_count),
    .trig_latency (trig_latency)
  );

  int n_cmp = 0;
  int n_err = 0;

  // stimulus per cycle after the arm cycle, and the expected buffer image
  logic [W-1:0] stim_d [4][MAXC];
  logic         stim_v [MAXC];
  logic         stim_e [MAXC];
  logic [W-1:0] model_mem [DEPTH];
  bit           model_ok  [DEPTH];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_div_a);
    #1;
  endtask

  task automatic drive_quiet;
    arm = 1'b0; disarm = 1'b0; din_valid = 1'b0; trig_ext = 1'b0;
  endtask

  task automatic drive_stim(input int i);
    din_valid = stim_v[i];
    trig_ext  = stim_e[i];
    dataA_in  = stim_d[0][i];
    dataB_in  = stim_d[1][i];
    dataC_in  = stim_d[2][i];
    dataD_in  = stim_d[3][i];
  endtask

  function automatic bit word_above(input logic [W-1:0] w, input logic [9:0] thr);
    bit hit = 1'b0;
    for (int s = 0; s < SR; s++) begin
      if (int'($signed(w[10*s +: 10])) > int'($signed(thr))) hit = 1'b1;
    end
    return hit;
  endfunction

  // Random words whose samples sit at or below thr, with an occasional
  // sample pushed above it (lvl_pct percent of words).
  task automatic gen_random(input int n, input int pv, input int pe,
                            input logic [9:0] thr, input int lvl_pct);
    int t;
    int v;
    t = int'($signed(thr));
    for (int i = 0; i < n; i++) begin
      stim_v[i] = (($urandom % 100) < pv);
      stim_e[i] = (($urandom % 100) < pe);
      for (int c = 0; c < 4; c++) begin
        for (int s = 0; s < SR; s++) begin
          v = t - int'($urandom_range(0, 200));
          if (v < -512) v = -512;
          stim_d[c][i][10*s +: 10] = 10'(v);
        end
        if (t < 511 && (($urandom % 100) < lvl_pct)) begin
          v = t + 1 + int'($urandom_range(0, 510 - t));
          stim_d[c][i][10*($urandom % SR) +: 10] = 10'(v);
        end
      end
    end
  endtask

  // Reference: walk the valid words in order, find the first that satisfies
  // the trigger rule, then take it and the following valid words up to target.
  task automatic model_run(input int ch, input int mode, input logic [9:0] thr,
                           input int nw, input int n,
                           output int trig, output int last, output int lat, output int cnt);
    int  target;
    bit  fires;
    target = (nw == 0 || nw > DEPTH) ? DEPTH : nw;
    trig = -1; last = -1; lat = 0; cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (!stim_v[i]) continue;
      if (trig < 0) begin
        case (mode)
          1:       fires = stim_e[i];
          2:       fires = word_above(stim_d[ch][i], thr);
          default: fires = 1'b1;
        endcase
        if (!fires) begin
          lat++;
          continue;
        end
        trig = i;
      end
      model_mem[cnt] = stim_d[ch][i];
      model_ok[cnt]  = 1'b1;
      cnt++;
      if (cnt == target) begin
        last = i;
        break;
      end
    end
  endtask

  // Reads back every captured word plus the next address (if it holds a known
  // earlier value) to show nothing was written past the end.
  task automatic readback(input string tag, input int cnt);
    int top;
    top = cnt;
    if (cnt < DEPTH && model_ok[cnt]) top = cnt + 1;
    for (int a = 0; a < top; a++) begin
      rd_addr = DL'(a);
      tick;
      check($sformatf("%s rd[%0d]", tag, a), rd_data, model_mem[a]);
    end
  endtask

  task automatic run_capture(input string tag, input int ch, input int mode,
                             input logic [9:0] thr, input int nw, input int n);
    int e_trig, e_last, e_lat, e_cnt;
    int first_done;
    logic [DL:0] wc_at_trig;
    model_run(ch, mode, thr, nw, n, e_trig, e_last, e_lat, e_cnt);

    // arm cycle carries a valid, triggering-looking word that must be ignored
    ch_sel = 2'(ch); trig_mode = 2'(mode); thresh = thr; num_words = (DL+1)'(nw);
    arm = 1'b1; din_valid = 1'b1; trig_ext = 1'b1;
    dataA_in = '1; dataB_in = '1; dataC_in = '1; dataD_in = '1;
    tick;
    arm = 1'b0; din_valid = 1'b0; trig_ext = 1'b0;
    ch_sel = ~ch_sel; trig_mode = ~trig_mode; thresh = ~thresh; num_words = (DL+1)'($urandom);
    check({tag, " busy@arm"}, W'(busy), W'(1));
    check({tag, " done@arm"}, W'(done), W'(0));
    check({tag, " wrcnt@arm"}, W'(wr_count), W'(0));
    check({tag, " lat@arm"}, W'(trig_latency), W'(0));

    first_done = -1;
    wc_at_trig = '0;
    for (int i = 0; i < n; i++) begin
      drive_stim(i);
      tick;
      if (i == e_trig) wc_at_trig = wr_count;
      if (done === 1'b1) begin
        first_done = i;
        break;
      end
    end
    din_valid = 1'b0; trig_ext = 1'b0;

    check({tag, " done_cycle"}, W'(first_done), W'(e_last));
    if (e_trig >= 0) check({tag, " wrcnt@trig"}, W'(wc_at_trig), W'(1));
    check({tag, " wr_count"}, W'(wr_count), W'(e_cnt));
    check({tag, " trig_latency"}, W'(trig_latency), W'(e_lat));
    if (e_last >= 0) begin
      check({tag, " done"}, W'(done), W'(1));
      check({tag, " busy"}, W'(busy), W'(0));
    end else begin
      check({tag, " done(pending)"}, W'(done), W'(0));
      check({tag, " busy(pending)"}, W'(busy), W'(1));
      disarm = 1'b1;
      tick;
      disarm = 1'b0;
      check({tag, " busy@disarm"}, W'(busy), W'(0));
    end
    readback(tag, e_cnt);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] kk;
    logic [9:0] thr;
    int         ch, mode, nw;

    drive_quiet();
    rst = 1'b1;
    ch_sel = '0; trig_mode = '0; thresh = '0; num_words = '0; rd_addr = '0;
    dataA_in = '0; dataB_in = '0; dataC_in = '0; dataD_in = '0;
    repeat (3) tick;
    rst = 1'b0;
    check("reset rd_data", rd_data, W'(0));
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset wr_count", W'(wr_count), W'(0));
    check("reset trig_latency", W'(trig_latency), W'(0));
    tick;

    // immediate, channel B, 4 words, continuous valid, word k = {8{k}}
    gen_random(10, 100, 0, 10'sd100, 0);
    for (int k = 0; k < 10; k++) begin
      kk = 10'(k);
      stim_d[1][k] = {SR{kk}};
    end
    run_capture("imm_chB", 1, 0, 10'd0, 4, 10);

    // level, channel C, thresh 100: max samples 50, 50, 101
    gen_random(12, 100, 0, 10'sd100, 20);
    for (int k = 0; k < 3; k++) begin
      stim_d[2][k] = {SR{10'd20}};
      for (int c = 0; c < 4; c++) if (c != 2) stim_d[c][k] = {SR{10'd200}};
    end
    stim_d[2][0][30 +: 10] = 10'd50;
    stim_d[2][1][50 +: 10] = 10'd50;
    stim_d[2][2][70 +: 10] = 10'd101;
    run_capture("level_chC", 2, 2, 10'd100, 5, 12);

    // external: valid toggles, trig_ext on an invalid cycle first, then valid
    gen_random(20, 0, 0, 10'sd0, 0);
    for (int i = 0; i < 20; i++) stim_v[i] = (i % 2 == 0);
    stim_e[3] = 1'b1;
    stim_e[6] = 1'b1;
    run_capture("ext_chA", 0, 1, 10'd0, 3, 20);

    // level trigger with thresh=+511 can never fire
    gen_random(30, 80, 50, 10'sd511, 50);
    run_capture("thr511", 3, 2, 10'sd511, 4, 30);

    // num_words=0 -> full depth, no wrap
    gen_random(1700, 70, 0, 10'sd0, 0);
    run_capture("full0", 3, 0, 10'd0, 0, 1700);

    // a few randomized configurations, including reserved mode 3
    for (int r = 0; r < 6; r++) begin
      ch   = int'($urandom % 4);
      mode = int'($urandom % 4);
      thr  = 10'(int'($urandom_range(0, 400)) - 100);
      nw   = 1 + int'($urandom % 40);
      if (r == 0) nw = 1;
      gen_random(300, 40 + int'($urandom % 61), 8, thr, 6);
      run_capture($sformatf("rand%0d", r), ch, mode, thr, nw, 300);
    end

    // disarm (with arm in the same cycle) after 5 captured words
    gen_random(10, 100, 0, 10'sd0, 0);
    ch_sel = 2'd0; trig_mode = 2'd0; thresh = '0; num_words = (DL+1)'(20);
    arm = 1'b1;
    tick;
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_stim(i);
      tick;
    end
    check("abort wr_count before", W'(wr_count), W'(5));
    drive_stim(5);
    disarm = 1'b1; arm = 1'b1;
    tick;
    drive_quiet();
    check("abort busy", W'(busy), W'(0));
    check("abort done", W'(done), W'(0));
    check("abort wr_count", W'(wr_count), W'(5));
    for (int a = 0; a < 5; a++) begin
      model_mem[a] = stim_d[0][a];
      model_ok[a]  = 1'b1;
    end
    readback("abort", 5);
    arm = 1'b1;
    tick;
    arm = 1'b0;
    check("rearm wr_count", W'(wr_count), W'(0));
    check("rearm busy", W'(busy), W'(1));
    disarm = 1'b1;
    tick;
    disarm = 1'b0;

    // reset while waiting for an external trigger
    ch_sel = 2'd3; trig_mode = 2'd1; num_words = (DL+1)'(3);
    arm = 1'b1;
    tick;
    arm = 1'b0;
    din_valid = 1'b1; trig_ext = 1'b0;
    repeat (3) tick;
    check("rst pre lat", W'(trig_latency), W'(3));
    rd_addr = '0;
    dataD_in = '1;
    rst = 1'b1; trig_ext = 1'b1;
    tick;
    rst = 1'b0;
    check("rst rd_data", rd_data, W'(0));
    check("rst busy", W'(busy), W'(0));
    check("rst done", W'(done), W'(0));
    check("rst wr_count", W'(wr_count), W'(0));
    check("rst trig_latency", W'(trig_latency), W'(0));
    repeat (4) tick;
    check("post rst busy", W'(busy), W'(0));
    check("post rst wr_count", W'(wr_count), W'(0));
    drive_quiet();
    readback("post rst", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
